// File: rtl/vga_scan_ctrl_if.sv
// vga_scan_ctrl_if: VRAM read port and VGA connector signals of the scan controller.
// test_mode exists only when VGA_TEST_PATTERN_EN is defined.
interface vga_scan_ctrl_if;
    logic [13:0] vram_addr;
    logic        vram_red;
    logic        vram_green;
    logic        vram_blue;
    logic [3:0]  vga_red;
    logic [3:0]  vga_green;
    logic [3:0]  vga_blue;
    logic        vga_hsync;
    logic        vga_vsync;
    logic        frame_start;
`ifdef VGA_TEST_PATTERN_EN
    logic        test_mode;
    modport master (
        output vram_addr, vga_red, vga_green, vga_blue, vga_hsync, vga_vsync, frame_start,
        input  vram_red, vram_green, vram_blue, test_mode
    );
    modport slave (
        input  vram_addr, vga_red, vga_green, vga_blue, vga_hsync, vga_vsync, frame_start,
        output vram_red, vram_green, vram_blue, test_mode
    );
`else
    modport master (
        output vram_addr, vga_red, vga_green, vga_blue, vga_hsync, vga_vsync, frame_start,
        input  vram_red, vram_green, vram_blue
    );
    modport slave (
        input  vram_addr, vga_red, vga_green, vga_blue, vga_hsync, vga_vsync, frame_start,
        output vram_red, vram_green, vram_blue
    );
`endif
endinterface

// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: 640x480@60 VGA timing generator fetching a SCALE-upscaled 1-bpp RGB image from VRAM.
// Optional VGA_TEST_PATTERN_EN adds test_mode, replacing VRAM colour with eight vertical colour bars.
module vga_scan_ctrl #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SCALE    = 5
) (
    input logic             clk,
    input logic             reset,
    vga_scan_ctrl_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW = $clog2(CLK_DIV);
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int SW = $clog2(SCALE + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_END = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_END = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [SW-1:0] SUB_LAST = SW'(SCALE - 1);

    logic [DW-1:0] div;
    logic [HW-1:0] hcount, h_nx;
    logic [VW-1:0] vcount, v_nx;
    logic [SW-1:0] hsub, vsub, hsub_nx, vsub_nx;
    logic [6:0]    col, row, col_nx, row_nx;
    logic          tick, h_wrap, v_wrap, v_restart;
    logic          h_act, v_act, h_act_nx, v_act_nx, h_step, v_step;
    logic          in_hsync, in_vsync;
    logic          color_r, color_g, color_b;

    // Everything is derived from the position being left (hcount/vcount) and the one being entered (*_nx).
    always_comb begin
        tick      = div == DIV_LAST;
        h_wrap    = hcount == H_LAST;
        v_wrap    = vcount == V_LAST;
        v_restart = h_wrap && v_wrap;
        h_nx      = h_wrap ? '0 : hcount + HW'(1);
        v_nx      = !h_wrap ? vcount : v_wrap ? '0 : vcount + VW'(1);
        h_act     = hcount < H_END;
        v_act     = vcount < V_END;
        h_act_nx  = h_nx < H_END;
        v_act_nx  = v_nx < V_END;
        h_step    = !h_wrap && h_act_nx;
        v_step    = h_wrap && !v_wrap && v_act_nx;
        hsub_nx   = h_wrap ? '0 : !h_step ? hsub : hsub == SUB_LAST ? '0 : hsub + SW'(1);
        col_nx    = h_wrap ? '0 : (h_step && hsub == SUB_LAST) ? col + 7'd1 : col;
        vsub_nx   = v_restart ? '0 : !v_step ? vsub : vsub == SUB_LAST ? '0 : vsub + SW'(1);
        row_nx    = v_restart ? '0 : (v_step && vsub == SUB_LAST) ? row + 7'd1 : row;
        in_hsync  = hcount >= HS_BEG && hcount < HS_END;
        in_vsync  = vcount >= VS_BEG && vcount < VS_END;
`ifdef VGA_TEST_PATTERN_EN
        color_r   = bus.test_mode ? col[6] : bus.vram_red;
        color_g   = bus.test_mode ? col[5] : bus.vram_green;
        color_b   = bus.test_mode ? col[4] : bus.vram_blue;
`else
        color_r   = bus.vram_red;
        color_g   = bus.vram_green;
        color_b   = bus.vram_blue;
`endif
    end

    // Outputs register the position being left, one pixel after its address was issued.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div             <= '0;
            hcount          <= '0;
            vcount          <= '0;
            hsub            <= '0;
            vsub            <= '0;
            col             <= '0;
            row             <= '0;
            bus.vram_addr   <= '0;
            bus.vga_red     <= '0;
            bus.vga_green   <= '0;
            bus.vga_blue    <= '0;
            bus.vga_hsync   <= 1'b1;
            bus.vga_vsync   <= 1'b1;
            bus.frame_start <= 1'b0;
        end else begin
            div             <= tick ? '0 : div + DW'(1);
            bus.frame_start <= tick && hcount == '0 && vcount == '0;
            if (tick) begin
                hcount        <= h_nx;
                vcount        <= v_nx;
                hsub          <= hsub_nx;
                vsub          <= vsub_nx;
                col           <= col_nx;
                row           <= row_nx;
                if (h_act_nx && v_act_nx)
                    bus.vram_addr <= {row_nx, col_nx};
                bus.vga_red   <= {4{h_act && v_act && color_r}};
                bus.vga_green <= {4{h_act && v_act && color_g}};
                bus.vga_blue  <= {4{h_act && v_act && color_b}};
                bus.vga_hsync <= !in_hsync;
                bus.vga_vsync <= !in_vsync;
            end
        end
    end
endmodule

// File: tb/tb_vga_scan_ctrl.sv
// tb_vga_scan_ctrl: a default-timing DUT checked against clock-indexed vectors, and a reduced-timing
// DUT checked pixel by pixel against scoreboard expectations from an independent position model.
`timescale 1ns/1ps
module tb_vga_scan_ctrl;
    localparam int SD = 2, SHA = 20, SHF = 2, SHS = 3, SHB = 3, SVA = 10, SVF = 1, SVS = 2, SVB = 2, SSC = 5;
    localparam int SHT = SHA + SHF + SHS + SHB;
    localparam int SVT = SVA + SVF + SVS + SVB;
    localparam int SFR = SHT * SVT;

    typedef struct {
        logic [13:0] addr;
        logic [3:0]  r, g, b;
        logic        hs, vs, fs;
    } exp_t;
    typedef struct {
        int   e;
        exp_t x;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        rst_s = 1'b0;
    logic [13:0] a_q = '0;
    logic [28:0] big_o, sml_o;
    int          ecount = 0;
    int          tests = 0;
    int          fails = 0;
    exp_t        sb[$];
    exp_t        rst_x;
    vec_t        vt[0:21];

    vga_scan_ctrl_if bif();
    vga_scan_ctrl_if sif();

    vga_scan_ctrl u_big (.clk(clk), .reset(rst_b), .bus(bif));

    vga_scan_ctrl #(
        .CLK_DIV(SD), .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .SCALE(SSC)
    ) u_sml (.clk(clk), .reset(rst_s), .bus(sif));

    assign big_o = {bif.vram_addr, bif.vga_red, bif.vga_green, bif.vga_blue, bif.vga_hsync, bif.vga_vsync, bif.frame_start};
    assign sml_o = {sif.vram_addr, sif.vga_red, sif.vga_green, sif.vga_blue, sif.vga_hsync, sif.vga_vsync, sif.frame_start};

    always #5 clk = ~clk;
    always @(posedge clk) ecount <= rst_b ? ecount + 1 : 0;

    function automatic logic [28:0] pk(input exp_t x);
        return {x.addr, x.r, x.g, x.b, x.hs, x.vs, x.fs};
    endfunction

    function automatic vec_t mkv(input int e, input int a, input logic [11:0] rgb, input logic hs, input logic fs);
        vec_t t;
        t.e = e;
        t.x = '{14'(a), rgb[11:8], rgb[7:4], rgb[3:0], hs, 1'b1, fs};
        return t;
    endfunction

    function automatic logic [2:0] pix(input logic [13:0] a);
        return {a[0] ^ a[7], a[1], a[7]};
    endfunction

    function automatic logic [13:0] ad(input int h, input int v);
        return 14'(((v / SSC) << 7) + h / SSC);
    endfunction

    // Output tick k shows frame position k; the address then points at position k+1 (held in blanking).
    function automatic exp_t model(input int k);
        int p = k % SFR;
        int q = (k + 1) % SFR;
        int h = p % SHT;
        int v = p / SHT;
        int hq = q % SHT;
        int vq = q / SHT;
        logic [2:0] c;
        exp_t x;
        x.addr = vq >= SVA ? ad(SHA - 1, SVA - 1) : hq >= SHA ? ad(SHA - 1, vq) : ad(hq, vq);
        c = (h < SHA && v < SVA) ? pix(ad(h, v)) : 3'b000;
        x.r = {4{c[2]}};
        x.g = {4{c[1]}};
        x.b = {4{c[0]}};
        x.hs = !(h >= SHA + SHF && h < SHA + SHF + SHS);
        x.vs = !(v >= SVA + SVF && v < SVA + SVF + SVS);
        x.fs = p == 0;
        return x;
    endfunction

    task automatic check(input string name, input logic [28:0] act, input logic [28:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t x);
        do @(negedge clk); while (ecount < x.e);
        check($sformatf("big@clk%0d", x.e), big_o, pk(x.x));
    endtask

    task automatic run_sb(input int n);
        exp_t x;
        for (int k = 0; k < n; k++) sb.push_back(model(k));
        for (int k = 0; k < n; k++) begin
            repeat (SD - 1) begin
                @(negedge clk);
                check($sformatf("sml_fs_low@%0d", k), 29'(sif.frame_start), 29'd0);
            end
            @(negedge clk);
            x = sb.pop_front();
            check($sformatf("sml_pix@%0d", k), sml_o, pk(x));
        end
    endtask

    // VRAM model for the reduced DUT: registered read of the captured address.
    initial begin
        forever begin
            @(negedge clk);
            {sif.vram_red, sif.vram_green, sif.vram_blue} = pix(a_q);
            a_q = sif.vram_addr;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        {bif.vram_red, bif.vram_green, bif.vram_blue} = 3'b111;
`ifdef VGA_TEST_PATTERN_EN
        bif.test_mode = 1'b0;
        sif.test_mode = 1'b0;
`endif
        rst_x = '{14'd0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0};
        vt = '{
            mkv(3, 0, 12'h000, 1, 0),      mkv(4, 0, 12'hFFF, 1, 1),      mkv(5, 0, 12'hFFF, 1, 0),
            mkv(19, 0, 12'hFFF, 1, 0),     mkv(20, 1, 12'hFFF, 1, 0),     mkv(39, 1, 12'hFFF, 1, 0),
            mkv(40, 2, 12'hFFF, 1, 0),     mkv(2556, 127, 12'hFFF, 1, 0), mkv(2563, 127, 12'hFFF, 1, 0),
            mkv(2564, 127, 12'h000, 1, 0), mkv(2627, 127, 12'h000, 1, 0), mkv(2628, 127, 12'h000, 0, 0),
            mkv(3011, 127, 12'h000, 0, 0), mkv(3012, 127, 12'h000, 1, 0), mkv(3203, 0, 12'h000, 1, 0),
            mkv(3204, 0, 12'hFFF, 1, 0),   mkv(5827, 127, 12'h000, 1, 0), mkv(5828, 127, 12'h000, 0, 0),
            mkv(15999, 127, 12'h000, 1, 0), mkv(16000, 128, 12'h000, 1, 0), mkv(16004, 128, 12'hFFF, 1, 0),
            mkv(16020, 129, 12'hFFF, 1, 0)
        };
        repeat (3) @(negedge clk);
        check("big_reset", big_o, pk(rst_x));
        check("sml_reset", sml_o, pk(rst_x));
        rst_b = 1'b1;
        foreach (vt[i]) run_vec(vt[i]);
`ifdef VGA_TEST_PATTERN_EN
        {bif.vram_red, bif.vram_green, bif.vram_blue} = 3'b000;
        bif.test_mode = 1'b1;
        run_vec(mkv(19364, 136, 12'h000, 1, 0));
        run_vec(mkv(19604, 148, 12'h00F, 1, 0));
        run_vec(mkv(21604, 248, 12'hFFF, 1, 0));
`endif
        @(negedge clk);
        rst_s = 1'b1;
        run_sb(600);
        #2 rst_s = 1'b0;
        #1 check("sml_async_reset", sml_o, pk(rst_x));
        repeat (2) @(negedge clk);
        rst_s = 1'b1;
        run_sb(SFR + 5);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
